// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial R-type ALU: funct codes, slice op codes,
// FSM state encoding and the funct decoder.
package alu_pkg;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_AND = 2'b00;
  localparam logic [1:0] ALUOP_OR  = 2'b01;
  localparam logic [1:0] ALUOP_SUM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  typedef struct packed {
    logic       ainv;
    logic       binv;
    logic       cin;
    logic [1:0] op;
    logic       is_slt;
    logic       legal;
  } ctrl_t;

  function automatic ctrl_t decode_funct(input logic [5:0] funct);
    ctrl_t c;
    c       = '0;
    c.legal = 1'b1;
    case (funct)
      FUNCT_ADD: c.op = ALUOP_SUM;
      FUNCT_SUB: begin
        c.binv = 1'b1;
        c.cin  = 1'b1;
        c.op   = ALUOP_SUM;
      end
      FUNCT_AND: c.op = ALUOP_AND;
      FUNCT_OR:  c.op = ALUOP_OR;
      FUNCT_NOR: begin
        c.ainv = 1'b1;
        c.binv = 1'b1;
        c.op   = ALUOP_AND;
      end
      FUNCT_SLT: begin
        c.binv   = 1'b1;
        c.cin    = 1'b1;
        c.op     = ALUOP_SUM;
        c.is_slt = 1'b1;
      end
      default: c.legal = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: and/or/sum with optional operand inversion,
// ripple carry in/out and a per-bit zero flag.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       ainv_i,
  input  logic       binv_i,
  input  logic       cin_i,
  input  logic [1:0] op_i,
  output logic       res_o,
  output logic       cout_o,
  output logic       zero_o
);

  logic aa;
  logic bb;

  assign aa     = a_i ^ ainv_i;
  assign bb     = b_i ^ binv_i;
  assign cout_o = (aa & bb) | (cin_i & (aa ^ bb));

  always_comb begin
    res_o = 1'b0;
    case (op_i)
      ALUOP_AND: res_o = aa & bb;
      ALUOP_OR:  res_o = aa | bb;
      ALUOP_SUM: res_o = aa ^ bb ^ cin_i;
      default:   res_o = 1'b0;
    endcase
  end

  assign zero_o = ~res_o;

endmodule

// File: rtl/rtype_serial_alu_ctrl.sv
// Bit-serial R-type execute unit: one ALU slice reused LSB-first over WIDTH cycles.
// Define ALU_OVF_EN to add the out_ovf signed-overflow output for add/sub.
module rtype_serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [5:0]       in_funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_err
`ifdef ALU_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             ainv_q;
  logic             binv_q;
  logic [1:0]       op_q;
  logic             slt_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             err_q;
  logic             in_ready_q;
  logic             out_valid_q;

  ctrl_t dec;
  logic  slice_res;
  logic  slice_cout;
  logic  slice_zero;
  logic  cin_msb;
  logic  slt_set;

  assign dec = decode_funct(in_funct);

  alu_bit_slice u_slice (
    .a_i    (a_q[idx_q]),
    .b_i    (b_q[idx_q]),
    .ainv_i (ainv_q),
    .binv_i (binv_q),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .res_o  (slice_res),
    .cout_o (slice_cout),
    .zero_o (slice_zero)
  );

  // On the MSB step the registered carry is the carry into the MSB.
  assign cin_msb = carry_q;
  assign slt_set = slice_res ^ (cin_msb ^ slice_cout);

`ifdef ALU_OVF_EN
  logic ovf_q;
  assign out_ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      ainv_q      <= 1'b0;
      binv_q      <= 1'b0;
      op_q        <= ALUOP_AND;
      slt_q       <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_q        <= in_a;
            b_q        <= in_b;
            ainv_q     <= dec.ainv;
            binv_q     <= dec.binv;
            op_q       <= dec.op;
            slt_q      <= dec.is_slt;
            idx_q      <= '0;
            carry_q    <= dec.cin;
            result_q   <= '0;
            zero_q     <= 1'b1;
            in_ready_q <= 1'b0;
`ifdef ALU_OVF_EN
            ovf_q      <= 1'b0;
`endif
            if (dec.legal) begin
              state_q <= ST_RUN;
              err_q   <= 1'b0;
            end else begin
              state_q     <= ST_DONE;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          result_q[idx_q] <= slice_res;
          zero_q          <= zero_q & slice_zero;
          carry_q         <= slice_cout;
          idx_q           <= idx_q + 1'b1;
          if (idx_q == IDX_LAST) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            // slt replaces the whole word with the overflow-corrected sign bit.
            if (slt_q) begin
              result_q <= {{(WIDTH-1){1'b0}}, slt_set};
              zero_q   <= ~slt_set;
            end
`ifdef ALU_OVF_EN
            ovf_q <= (op_q == ALUOP_SUM) & ~slt_q & (cin_msb ^ slice_cout);
`endif
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = result_q;
  assign out_zero   = zero_q;
  assign out_err    = err_q;

endmodule

// File: tb/tb_rtype_serial_alu_ctrl.sv
// Scoreboard bench for rtype_serial_alu_ctrl (WIDTH=32); out_ovf checked when ALU_OVF_EN is defined.
module tb_rtype_serial_alu_ctrl;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [5:0]       in_funct;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_err;
`ifdef ALU_OVF_EN
  logic             out_ovf;
`endif

  rtype_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_funct   (in_funct),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_err    (out_err)
`ifdef ALU_OVF_EN
    ,
    .out_ovf    (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
    logic             ovf;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   t_acc   = 0;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    exp_t e;
    e.err = 1'b0;
    e.ovf = 1'b0;
    case (f)
      6'h20: begin
        e.res = a + b;
        e.ovf = (a[31] == b[31]) && (e.res[31] != a[31]);
      end
      6'h22: begin
        e.res = a - b;
        e.ovf = (a[31] != b[31]) && (e.res[31] != a[31]);
      end
      6'h24: e.res = a & b;
      6'h25: e.res = a | b;
      6'h27: e.res = ~(a | b);
      6'h2A: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: begin
        e.res = '0;
        e.err = 1'b1;
      end
    endcase
    e.zero = (e.res == '0);
    return e;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f);
    int n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_in_ready got %b want 1", in_ready);
    end
    in_a     = a;
    in_b     = b;
    in_funct = f;
    in_valid = 1'b1;
    t_acc    = cyc;
    sb.push_back(model(a, b, f));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit tmo);
    int n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tmo = (out_valid !== 1'b1);
    lat = cyc - t_acc;
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_funct  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== '0 ||
        out_zero !== 1'b0 || out_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got rdy=%b vld=%b res=%h z=%b e=%b want 1 0 0 0 0",
               in_ready, out_valid, out_result, out_zero, out_err);
    end
`ifdef ALU_OVF_EN
    n_tests++;
    if (out_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf got %b want 0", out_ovf);
    end
`endif
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ops();
    logic [31:0] ta[10];
    logic [31:0] tb[10];
    logic [5:0]  tf[10];
    exp_t        e;
    int          lat;
    int          want_lat;
    bit          tmo;
    ta = '{32'h7FFFFFFF, 32'h5, 32'hF0F0F0F0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h3,
           32'h0, 32'h0000FFFF, 32'h12345678, 32'h80000000};
    tb = '{32'h1, 32'h5, 32'hFF00FF00, 32'h1, 32'h80000000, 32'h3,
           32'h0, 32'h00FF0000, 32'h9ABCDEF0, 32'h1};
    tf = '{6'h20, 6'h22, 6'h24, 6'h2A, 6'h2A, 6'h2A, 6'h27, 6'h25, 6'h3F, 6'h22};
    for (int i = 0; i < 10; i++) begin
      issue(ta[i], tb[i], tf[i]);
      wait_out(lat, tmo);
      e = sb.pop_front();
      want_lat = e.err ? 1 : WIDTH + 1;
      n_tests++;
      if (tmo || lat != want_lat) begin
        n_fail++;
        $display("FAIL ops[%0d]_latency got %0d (timeout=%0b) want %0d", i, lat, tmo, want_lat);
      end
      n_tests++;
      if (out_result !== e.res || out_zero !== e.zero || out_err !== e.err) begin
        n_fail++;
        $display("FAIL ops[%0d]_result got %h z=%b e=%b want %h z=%b e=%b",
                 i, out_result, out_zero, out_err, e.res, e.zero, e.err);
      end
`ifdef ALU_OVF_EN
      n_tests++;
      if (out_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL ops[%0d]_ovf got %b want %b", i, out_ovf, e.ovf);
      end
`endif
      release_out();
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL ops[%0d]_handshake got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    int   lat;
    bit   tmo;
    int   bad = 0;
    issue(32'h12345678, 32'h11111111, 6'h20);
    wait_out(lat, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || lat != WIDTH + 1) begin
      n_fail++;
      $display("FAIL bp_latency got %0d (timeout=%0b) want %0d", lat, tmo, WIDTH + 1);
    end
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      in_a     = 32'hDEAD0000 + i;
      in_b     = 32'h1;
      in_funct = 6'h25;
      @(posedge clk); #1;
      n_tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_result !== e.res ||
          out_zero !== e.zero || out_err !== e.err) begin
        n_fail++;
        bad++;
        $display("FAIL bp_hold[%0d] got vld=%b rdy=%b res=%h want 1 0 %h",
                 i, out_valid, in_ready, out_result, e.res);
      end
    end
    in_valid = 1'b0;
    release_out();
    n_tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL bp_no_queue got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_reset_midrun();
    exp_t e;
    int   lat;
    bit   tmo;
    int   ghost = 0;
    issue(32'hAAAA5555, 32'h0F0F0F0F, 6'h22);
    repeat (17) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_reset got vld=%b rdy=%b want 0 1", out_valid, in_ready);
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ghost++;
    end
    n_tests++;
    if (ghost != 0) begin
      n_fail++;
      $display("FAIL midrun_discard got %0d valid cycles want 0", ghost);
    end
    issue(32'h7FFFFFFF, 32'h80000000, 6'h2A);
    wait_out(lat, tmo);
    e = sb.pop_front();
    n_tests++;
    if (tmo || lat != WIDTH + 1 || out_result !== e.res || out_zero !== e.zero) begin
      n_fail++;
      $display("FAIL midrun_next got %h z=%b lat=%0d want %h z=%b lat=%0d",
               out_result, out_zero, lat, e.res, e.zero, WIDTH + 1);
    end
    release_out();
  endtask

  task automatic test_back_to_back();
    logic [5:0] fl[7];
    exp_t       e;
    int         lat;
    int         want_lat;
    bit         tmo;
    logic [31:0] a;
    logic [31:0] b;
    fl = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h01};
    out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = (i % 5 == 0) ? a : $urandom;
      issue(a, b, fl[$urandom_range(0, 6)]);
      wait_out(lat, tmo);
      e = sb.pop_front();
      want_lat = e.err ? 1 : WIDTH + 1;
      n_tests++;
      if (tmo || lat != want_lat || out_result !== e.res || out_zero !== e.zero ||
          out_err !== e.err) begin
        n_fail++;
        $display("FAIL b2b[%0d] got %h z=%b e=%b lat=%0d want %h z=%b e=%b lat=%0d",
                 i, out_result, out_zero, out_err, lat, e.res, e.zero, e.err, want_lat);
      end
`ifdef ALU_OVF_EN
      n_tests++;
      if (out_ovf !== e.ovf) begin
        n_fail++;
        $display("FAIL b2b[%0d]_ovf got %b want %b", i, out_ovf, e.ovf);
      end
`endif
      @(posedge clk); #1;
      n_tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b[%0d]_bubble got rdy=%b vld=%b want 1 0", i, in_ready, out_valid);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_backpressure();
    test_reset_midrun();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
